// File: rtl/memory_access_pkg.sv
// Shared constants and access-size encoding for the MEM pipeline stage.
package memory_access_pkg;

    localparam int DATA_SIZE     = 32;
    localparam int PC_SIZE       = 32;
    localparam int REG_SIZE      = 5;
    localparam int MEM_DEPTH     = 32;
    localparam int MEM_ADDR_BITS = 5;

    // Access size of a load/store after priority resolution.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_BYTE = 2'd1,
        ACC_HALF = 2'd2,
        ACC_WORD = 2'd3
    } access_size_e;

    // Word beats halfword beats byte; nothing set means no access.
    function automatic access_size_e decode_size(input logic byte_en,
                                                 input logic half_en,
                                                 input logic word_en);
        access_size_e size;
        if (word_en) begin
            size = ACC_WORD;
        end else if (half_en) begin
            size = ACC_HALF;
        end else if (byte_en) begin
            size = ACC_BYTE;
        end else begin
            size = ACC_NONE;
        end
        return size;
    endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// Word-organised data memory with lane-masked writes, synchronous clear,
// a combinational main read port and a combinational debug read port.
import memory_access_pkg::*;

module data_memory #(
    parameter int DATA_SIZE     = 32,
    parameter int MEM_DEPTH     = 32,
    parameter int MEM_ADDR_BITS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_write,
    input  access_size_e             i_size,
    input  logic [MEM_ADDR_BITS-1:0] i_word_addr,
    input  logic [1:0]               i_lane,
    input  logic [DATA_SIZE-1:0]     i_wdata,
    output logic [DATA_SIZE-1:0]     o_rdata,
    input  logic [MEM_ADDR_BITS-1:0] i_debug_addr,
    output logic [DATA_SIZE-1:0]     o_debug_data
);

    logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [MEM_DEPTH];
    logic [DATA_SIZE-1:0] lane_mask;
    logic [DATA_SIZE-1:0] lane_data;

    // Build the lane mask and replicated write data; alignment is forced by
    // ignoring the low lane bits that do not apply to the access size.
    always_comb begin
        lane_mask = '0;
        lane_data = '0;
        case (i_size)
            ACC_BYTE: begin
                lane_mask = {{(DATA_SIZE-8){1'b0}}, 8'hFF} << {i_lane, 3'b000};
                lane_data = {4{i_wdata[7:0]}};
            end
            ACC_HALF: begin
                lane_mask = i_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_data = {2{i_wdata[15:0]}};
            end
            ACC_WORD: begin
                lane_mask = '1;
                lane_data = i_wdata;
            end
            default: begin
                lane_mask = '0;
                lane_data = '0;
            end
        endcase
    end

    // Next memory image: only the masked lanes of the addressed word change.
    always_comb begin
        mem_d = mem_q;
        if (i_write) begin
            mem_d[i_word_addr] = (mem_q[i_word_addr] & ~lane_mask) |
                                 (lane_data & lane_mask);
        end
    end

    // Storage; reset clears every word and drops any pending store.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rdata      = mem_q[i_word_addr];
    assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: branch resolution, data memory access with load
// extension, and the MEM/WB register (1-cycle latency, sticky halt).
import memory_access_pkg::*;

module memory_access #(
    parameter int DATA_SIZE     = 32,
    parameter int PC_SIZE       = 32,
    parameter int REG_SIZE      = 5,
    parameter int MEM_DEPTH     = 32,
    parameter int MEM_ADDR_BITS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_signed,
    input  logic                     i_reg_write,
    input  logic                     i_mem_to_reg,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,
    input  logic                     i_branch,
    input  logic                     i_zero,
    input  logic [PC_SIZE-1:0]       i_branch_addr,
    input  logic [DATA_SIZE-1:0]     i_alu_result,
    input  logic [DATA_SIZE-1:0]     i_data_b,
    input  logic [REG_SIZE-1:0]      i_selected_reg,
    input  logic                     i_byte_enable,
    input  logic                     i_halfword_enable,
    input  logic                     i_word_enable,
    input  logic                     i_last_register_ctrl,
    input  logic [PC_SIZE-1:0]       i_pc,
    input  logic                     i_halt,
    input  logic [MEM_ADDR_BITS-1:0] i_debug_addr,
    output logic                     o_pc_src,
    output logic [PC_SIZE-1:0]       o_branch_addr,
    output logic [DATA_SIZE-1:0]     o_mem_fwd_data,
    output logic                     o_reg_write,
    output logic                     o_mem_to_reg,
    output logic                     o_last_register_ctrl,
    output logic                     o_halt,
    output logic [DATA_SIZE-1:0]     o_read_data,
    output logic [DATA_SIZE-1:0]     o_alu_result,
    output logic [REG_SIZE-1:0]      o_selected_reg,
    output logic [PC_SIZE-1:0]       o_pc,
    output logic [DATA_SIZE-1:0]     o_debug_data
);

    access_size_e         size;
    logic [DATA_SIZE-1:0] mem_word;
    logic [DATA_SIZE-1:0] load_value;
    logic [7:0]           load_byte;
    logic [15:0]          load_half;

    logic                 reg_write_q,  reg_write_d;
    logic                 mem_to_reg_q, mem_to_reg_d;
    logic                 last_reg_q,   last_reg_d;
    logic                 halt_q,       halt_d;
    logic [DATA_SIZE-1:0] read_data_q,  read_data_d;
    logic [DATA_SIZE-1:0] alu_result_q, alu_result_d;
    logic [REG_SIZE-1:0]  sel_reg_q,    sel_reg_d;
    logic [PC_SIZE-1:0]   pc_q,         pc_d;

    assign size           = decode_size(i_byte_enable, i_halfword_enable, i_word_enable);
    assign o_pc_src       = i_branch & i_zero;
    assign o_branch_addr  = i_branch_addr;
    assign o_mem_fwd_data = i_alu_result;

    data_memory #(
        .DATA_SIZE     (DATA_SIZE),
        .MEM_DEPTH     (MEM_DEPTH),
        .MEM_ADDR_BITS (MEM_ADDR_BITS)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_write      (i_mem_write & i_enable & (size != ACC_NONE)),
        .i_size       (size),
        .i_word_addr  (i_alu_result[MEM_ADDR_BITS+1:2]),
        .i_lane       (i_alu_result[1:0]),
        .i_wdata      (i_data_b),
        .o_rdata      (mem_word),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data)
    );

    // Extract the addressed lane from the current word and extend it.
    always_comb begin
        load_byte  = mem_word[{i_alu_result[1:0], 3'b000} +: 8];
        load_half  = i_alu_result[1] ? mem_word[31:16] : mem_word[15:0];
        load_value = '0;
        if (i_mem_read) begin
            case (size)
                ACC_BYTE: load_value = i_signed ? {{(DATA_SIZE-8){load_byte[7]}}, load_byte}
                                                : {{(DATA_SIZE-8){1'b0}}, load_byte};
                ACC_HALF: load_value = i_signed ? {{(DATA_SIZE-16){load_half[15]}}, load_half}
                                                : {{(DATA_SIZE-16){1'b0}}, load_half};
                ACC_WORD: load_value = mem_word;
                default:  load_value = '0;
            endcase
        end
    end

    // MEM/WB next state: capture on enable, otherwise hold; halt is sticky.
    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        last_reg_d   = last_reg_q;
        halt_d       = halt_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        sel_reg_d    = sel_reg_q;
        pc_d         = pc_q;
        if (i_enable) begin
            reg_write_d  = i_reg_write;
            mem_to_reg_d = i_mem_to_reg;
            last_reg_d   = i_last_register_ctrl;
            halt_d       = halt_q | i_halt;
            read_data_d  = load_value;
            alu_result_d = i_alu_result;
            sel_reg_d    = i_selected_reg;
            pc_d         = i_pc;
        end
    end

    // MEM/WB register; reset wins over enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            last_reg_q   <= 1'b0;
            halt_q       <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            sel_reg_q    <= '0;
            pc_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            last_reg_q   <= last_reg_d;
            halt_q       <= halt_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            sel_reg_q    <= sel_reg_d;
            pc_q         <= pc_d;
        end
    end

    assign o_reg_write          = reg_write_q;
    assign o_mem_to_reg         = mem_to_reg_q;
    assign o_last_register_ctrl = last_reg_q;
    assign o_halt               = halt_q;
    assign o_read_data          = read_data_q;
    assign o_alu_result         = alu_result_q;
    assign o_selected_reg       = sel_reg_q;
    assign o_pc                 = pc_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: stores, loads, wrap, branch, hold, halt, reset.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        i_reset, i_enable, i_signed, i_reg_write, i_mem_to_reg;
    logic        i_mem_read, i_mem_write, i_branch, i_zero;
    logic [31:0] i_branch_addr, i_alu_result, i_data_b, i_pc;
    logic [4:0]  i_selected_reg, i_debug_addr;
    logic        i_byte_enable, i_halfword_enable, i_word_enable;
    logic        i_last_register_ctrl, i_halt;
    logic        o_pc_src, o_reg_write, o_mem_to_reg, o_last_register_ctrl, o_halt;
    logic [31:0] o_branch_addr, o_mem_fwd_data, o_read_data, o_alu_result, o_pc, o_debug_data;
    logic [4:0]  o_selected_reg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memory_access dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_signed(i_signed),
        .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_branch(i_branch), .i_zero(i_zero),
        .i_branch_addr(i_branch_addr), .i_alu_result(i_alu_result), .i_data_b(i_data_b),
        .i_selected_reg(i_selected_reg), .i_byte_enable(i_byte_enable),
        .i_halfword_enable(i_halfword_enable), .i_word_enable(i_word_enable),
        .i_last_register_ctrl(i_last_register_ctrl), .i_pc(i_pc), .i_halt(i_halt),
        .i_debug_addr(i_debug_addr), .o_pc_src(o_pc_src), .o_branch_addr(o_branch_addr),
        .o_mem_fwd_data(o_mem_fwd_data), .o_reg_write(o_reg_write),
        .o_mem_to_reg(o_mem_to_reg), .o_last_register_ctrl(o_last_register_ctrl),
        .o_halt(o_halt), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
        .o_selected_reg(o_selected_reg), .o_pc(o_pc), .o_debug_data(o_debug_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_reset = 0; i_enable = 1; i_signed = 0; i_reg_write = 0; i_mem_to_reg = 0;
        i_mem_read = 0; i_mem_write = 0; i_branch = 0; i_zero = 0;
        i_branch_addr = 0; i_alu_result = 0; i_data_b = 0; i_pc = 0;
        i_selected_reg = 0; i_byte_enable = 0; i_halfword_enable = 0;
        i_word_enable = 0; i_last_register_ctrl = 0; i_halt = 0; i_debug_addr = 0;
    endtask

    task automatic store(input logic b, input logic h, input logic w,
                         input logic [31:0] addr, input logic [31:0] data);
        idle();
        i_mem_write = 1; i_byte_enable = b; i_halfword_enable = h; i_word_enable = w;
        i_alu_result = addr; i_data_b = data; i_debug_addr = 5'd2;
        step();
    endtask

    task automatic load(input logic b, input logic h, input logic w, input logic sgn,
                        input logic [31:0] addr);
        idle();
        i_mem_read = 1; i_signed = sgn; i_byte_enable = b; i_halfword_enable = h;
        i_word_enable = w; i_alu_result = addr; i_debug_addr = 5'd2;
        step();
    endtask

    initial begin
        idle();
        // Reset with a pending store: nothing may be written.
        i_reset = 1; i_mem_write = 1; i_word_enable = 1; i_alu_result = 32'h8;
        i_data_b = 32'h5555_5555; i_halt = 1; i_pc = 32'h44;
        step(); step();
        idle(); i_debug_addr = 5'd2; #1;
        check("rst_read_data", o_read_data, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_halt", {31'b0, o_halt}, 32'h0);
        check("rst_mem2", o_debug_data, 32'h0);

        // Word store plus pipeline register capture.
        idle();
        i_mem_write = 1; i_word_enable = 1; i_alu_result = 32'h8; i_data_b = 32'hDEAD_BEEF;
        i_selected_reg = 5'd5; i_pc = 32'h104; i_reg_write = 1; i_debug_addr = 5'd2;
        step();
        check("st_word", o_debug_data, 32'hDEAD_BEEF);
        check("wb_alu", o_alu_result, 32'h8);
        check("wb_sel", {27'b0, o_selected_reg}, 32'd5);
        check("wb_pc", o_pc, 32'h104);
        check("wb_regw", {31'b0, o_reg_write}, 32'h1);
        check("wb_noread", o_read_data, 32'h0);

        // Signed byte load from lane 3; forward path is combinational.
        idle();
        i_mem_read = 1; i_signed = 1; i_byte_enable = 1; i_alu_result = 32'hB; i_mem_to_reg = 1;
        #1;
        check("fwd", o_mem_fwd_data, 32'hB);
        step();
        check("ld_sbyte", o_read_data, 32'hFFFF_FFDE);
        check("wb_m2r", {31'b0, o_mem_to_reg}, 32'h1);

        load(1, 0, 0, 0, 32'hB);
        check("ld_ubyte", o_read_data, 32'h0000_00DE);
        load(0, 1, 0, 1, 32'hB);
        check("ld_shalf_unaligned", o_read_data, 32'hFFFF_DEAD);

        store(1, 0, 0, 32'h9, 32'h1234_567F);
        check("st_byte", o_debug_data, 32'hDEAD_7FEF);
        load(0, 1, 0, 0, 32'h8);
        check("ld_uhalf", o_read_data, 32'h0000_7FEF);
        load(1, 0, 0, 1, 32'h9);
        check("ld_sbyte_pos", o_read_data, 32'h0000_007F);

        store(0, 1, 0, 32'h9, 32'hAAAA_1234);
        check("st_half_align", o_debug_data, 32'hDEAD_1234);
        store(1, 1, 1, 32'hA, 32'h1122_3344);
        check("st_prio_word", o_debug_data, 32'h1122_3344);
        store(0, 0, 0, 32'h8, 32'hFFFF_FFFF);
        check("st_no_size", o_debug_data, 32'h1122_3344);

        // Address wrap: 0x84 -> word index 1.
        store(0, 0, 1, 32'h84, 32'hCAFE_F00D);
        check("wrap_mem2", o_debug_data, 32'h1122_3344);
        i_debug_addr = 5'd1; #1;
        check("wrap_mem1", o_debug_data, 32'hCAFE_F00D);

        idle();
        i_mem_read = 1; i_signed = 1; i_word_enable = 1; i_alu_result = 32'h84;
        i_last_register_ctrl = 1;
        step();
        check("ld_word", o_read_data, 32'hCAFE_F00D);
        check("wb_link", {31'b0, o_last_register_ctrl}, 32'h1);

        idle();
        i_byte_enable = 1; i_alu_result = 32'h84; i_pc = 32'h200;
        step();
        check("ld_disabled", o_read_data, 32'h0);

        // Branch resolution is combinational.
        idle();
        i_branch = 1; i_zero = 1; i_branch_addr = 32'h40; #1;
        check("br_taken", {31'b0, o_pc_src}, 32'h1);
        check("br_addr", o_branch_addr, 32'h40);
        i_zero = 0; #1;
        check("br_not_taken", {31'b0, o_pc_src}, 32'h0);

        // Disabled stage: store blocked, register holds.
        idle();
        i_enable = 0; i_mem_write = 1; i_word_enable = 1; i_alu_result = 32'h84;
        i_data_b = 32'h0; i_pc = 32'h300; i_debug_addr = 5'd1;
        step();
        check("hold_mem", o_debug_data, 32'hCAFE_F00D);
        check("hold_alu", o_alu_result, 32'h84);
        check("hold_pc", o_pc, 32'h200);

        // Sticky halt.
        idle(); i_halt = 1; step();
        check("halt_set", {31'b0, o_halt}, 32'h1);
        idle(); step(); step(); step();
        check("halt_sticky", {31'b0, o_halt}, 32'h1);

        // Reset during an enabled store clears everything.
        idle();
        i_reset = 1; i_mem_write = 1; i_word_enable = 1; i_alu_result = 32'h84;
        i_data_b = 32'h1234_5678; i_pc = 32'h500; i_debug_addr = 5'd1;
        step();
        idle(); i_debug_addr = 5'd1; #1;
        check("rst2_mem1", o_debug_data, 32'h0);
        i_debug_addr = 5'd2; #1;
        check("rst2_mem2", o_debug_data, 32'h0);
        check("rst2_alu", o_alu_result, 32'h0);
        check("rst2_pc", o_pc, 32'h0);
        check("rst2_halt", {31'b0, o_halt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameters SHALL be: DATA_SIZE=32, data width; PC_SIZE=32, PC width; REG_SIZE=5, register index width; MEM_DEPTH=32, words of data memory; MEM_ADDR_BITS=5, word index width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Ports (name, direction, width, meaning):
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_enable  in  1  pipeline advance / debug step
- i_signed  in  1  load sign-extension
- i_reg_write  in  1  WB flag
- i_mem_to_reg  in  1  WB flag
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_branch  in  1  branch instruction
- i_zero  in  1  ALU zero
- i_branch_addr  in  PC_SIZE  branch target
- i_alu_result  in  DATA_SIZE  byte address / ALU value
- i_data_b  in  DATA_SIZE  store data
- i_selected_reg  in  REG_SIZE  destination register
- i_byte_enable, i_halfword_enable, i_word_enable  in  1 each  access size
- i_last_register_ctrl  in  1  link write (JAL/JALR)
- i_pc  in  PC_SIZE  PC+4 of instruction
- i_halt  in  1  halt marker
- i_debug_addr  in  MEM_ADDR_BITS  debug word index
- o_pc_src  out  1  take branch
- o_branch_addr  out  PC_SIZE  target to IF
- o_mem_fwd_data  out  DATA_SIZE  forward to EX
- o_reg_write, o_mem_to_reg, o_last_register_ctrl, o_halt  out  1 each  registered flags
- o_read_data  out  DATA_SIZE  registered load value
- o_alu_result  out  DATA_SIZE  registered ALU value
- o_selected_reg  out  REG_SIZE  registered destination
- o_pc  out  PC_SIZE  registered PC+4
- o_debug_data  out  DATA_SIZE  memory word at i_debug_addr

Function
REQ-004 o_pc_src SHALL be i_branch AND i_zero, combinational; o_branch_addr = i_branch_addr.
REQ-005 o_mem_fwd_data SHALL equal i_alu_result combinationally.
REQ-006 Word index SHALL be i_alu_result[MEM_ADDR_BITS+1:2]; higher bits are ignored, so the address wraps modulo MEM_DEPTH words.
REQ-007 A store SHALL write on the rising edge when i_mem_write & i_enable & !i_reset. Byte: lane i_alu_result[1:0] <- i_data_b[7:0]. Halfword: lane pair i_alu_result[1] <- i_data_b[15:0]. Word: all 4 lanes <- i_data_b. Other lanes SHALL be unchanged.
REQ-008 Alignment SHALL be forced: a halfword ignores addr[0]; a word ignores addr[1:0].
REQ-009 If no size enable or more than one size enable is set, priority SHALL be word > halfword > byte; if none is set, no write occurs.
REQ-010 A load SHALL read the current word combinationally and extract the lane as in REQ-007; with i_signed=1 it sign-extends, otherwise it zero-extends; a word load passes through unchanged; if i_mem_read=0 the load value is 0.
REQ-011 On an edge with i_enable=1, the MEM/WB outputs SHALL capture: the load value, i_alu_result, i_selected_reg, i_pc, i_reg_write, i_mem_to_reg, i_last_register_ctrl, i_halt. Latency is 1 cycle.
REQ-012 With i_enable=0, MEM/WB outputs and memory SHALL hold, even if i_mem_write=1.
REQ-013 Once o_halt=1 is captured, o_halt SHALL stay 1 until reset, regardless of i_halt.
REQ-014 o_debug_data SHALL read combinationally, independent of i_enable; if a write hits the same word, the new value is visible the cycle after the edge.

Reset
REQ-015 When i_reset=1 at an edge: all registered outputs SHALL go to 0, all memory words SHALL go to 0, and no store occurs even if i_mem_write=1.
REQ-016 Reset SHALL override i_enable; a store pending during reset SHALL be dropped.

Structure
REQ-017 A shared package SHALL hold DATA_SIZE, PC_SIZE, REG_SIZE, MEM_DEPTH, MEM_ADDR_BITS, and the access-size encoding constants.
REQ-018 A single sub-module data_memory SHALL contain the storage, lane-masked write, reset clear, main read port and debug read port; the MEM/WB register and load extension SHALL stay in memory_access.

Verification
REQ-019 Store word 0xDEADBEEF at addr 0x8, then signed load byte at 0xB -> o_read_data=0xFFFFFFDE one cycle later.
REQ-020 Store byte 0x7F at 0x9 over word 0xDEADBEEF -> word=0xDEAD7FEF; unsigned halfword load at 0x8 -> 0x00007FEF.
REQ-021 Store word at addr 0x84 with MEM_DEPTH=32 -> word index 1 written; o_debug_data with i_debug_addr=1 shows the value.
REQ-022 i_branch=1, i_zero=1, i_branch_addr=0x40 -> o_pc_src=1 the same cycle; with i_zero=0 -> o_pc_src=0.
REQ-023 Store with i_enable=0 -> memory and outputs unchanged; assert i_reset during a store -> memory all 0 and all outputs 0.
REQ-024 i_halt=1 pulsed for one enabled cycle -> o_halt=1 persists until reset.
